// File: rtl/pcs_receive_decode.sv
// rtl/pcs_receive_decode.sv - 1000BASE-X PCS receive: 10b/8b decode, reduced receive FSM, error counter
// Optional feature macro: RX_DISP_CHECK_EN (running-disparity checking of received groups).
module pcs_receive_decode #(
    parameter int          ERR_CNT_W = 8,
    parameter logic [7:0]  PREAMBLE  = 8'h55,
    parameter logic [7:0]  FC_CODE   = 8'h0E
) (
    input  logic                 clock,
    input  logic                 mr_main_reset,
    input  logic [9:0]           SUDI,
    input  logic                 rx_even,
    input  logic                 code_sync_status,
    output logic [7:0]           RXD,
    output logic                 RX_DV,
    output logic                 RX_ER,
    output logic [ERR_CNT_W-1:0] rx_err_cnt
);

    typedef enum logic [2:0] {
        LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D,
        FALSE_CARRIER, START_OF_PACKET, RECEIVE, TRR
    } state_t;

    typedef enum logic [2:0] {CL_K285, CL_S, CL_T, CL_R, CL_D, CL_BAD} cls_t;

    // abcdei -> {valid, EDCBA}; both disparity columns accepted
    function automatic logic [5:0] dec6(input logic [5:0] c);
        case (c)
            6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
            6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
            6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
            6'b110001:            dec6 = {1'b1, 5'd3};
            6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
            6'b101001:            dec6 = {1'b1, 5'd5};
            6'b011001:            dec6 = {1'b1, 5'd6};
            6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
            6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
            6'b100101:            dec6 = {1'b1, 5'd9};
            6'b010101:            dec6 = {1'b1, 5'd10};
            6'b110100:            dec6 = {1'b1, 5'd11};
            6'b001101:            dec6 = {1'b1, 5'd12};
            6'b101100:            dec6 = {1'b1, 5'd13};
            6'b011100:            dec6 = {1'b1, 5'd14};
            6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
            6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
            6'b100011:            dec6 = {1'b1, 5'd17};
            6'b010011:            dec6 = {1'b1, 5'd18};
            6'b110010:            dec6 = {1'b1, 5'd19};
            6'b001011:            dec6 = {1'b1, 5'd20};
            6'b101010:            dec6 = {1'b1, 5'd21};
            6'b011010:            dec6 = {1'b1, 5'd22};
            6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
            6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
            6'b100110:            dec6 = {1'b1, 5'd25};
            6'b010110:            dec6 = {1'b1, 5'd26};
            6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
            6'b001110:            dec6 = {1'b1, 5'd28};
            6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
            6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
            6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
            default:              dec6 = 6'd0;
        endcase
    endfunction

    // fghj -> {valid, HGF}; primary and alternate x.7 forms both accepted
    function automatic logic [3:0] dec4(input logic [3:0] c);
        case (c)
            4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
            4'b1001:                            dec4 = {1'b1, 3'd1};
            4'b0101:                            dec4 = {1'b1, 3'd2};
            4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
            4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
            4'b1010:                            dec4 = {1'b1, 3'd5};
            4'b0110:                            dec4 = {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
            default:                            dec4 = 4'd0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [7:0]             rxd_q, rxd_d;
    logic                   dv_q, dv_d, er_q, er_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]             six;
    logic [3:0]             four;
    logic                   v6, v4, vk4, a7;
    logic [4:0]             x5;
    logic [2:0]             y3, yk3;
    logic [7:0]             rx_byte;
    cls_t                   cls;
    logic                   disp_ok;

`ifdef RX_DISP_CHECK_EN
    logic rd_q, rd_mid, rd_d;
    logic need_neg6, need_pos6, need_neg4, need_pos4;

    // Per-sub-block disparity legality and running-disparity update
    always_comb begin
        need_neg6 = ($countones(six) > 3) || (six == 6'b111000);
        need_pos6 = ($countones(six) < 3) || (six == 6'b000111);
        need_neg4 = ($countones(four) > 2) || (four == 4'b1100);
        need_pos4 = ($countones(four) < 2) || (four == 4'b0011);
        rd_mid    = rd_q;
        if (($countones(six) > 3) || (six == 6'b000111))      rd_mid = 1'b1;
        else if (($countones(six) < 3) || (six == 6'b111000)) rd_mid = 1'b0;
        rd_d      = rd_mid;
        if (($countones(four) > 2) || (four == 4'b0011))      rd_d = 1'b1;
        else if (($countones(four) < 2) || (four == 4'b1100)) rd_d = 1'b0;
        disp_ok   = !(need_neg6 && rd_q) && !(need_pos6 && !rd_q) &&
                    !(need_neg4 && rd_mid) && !(need_pos4 && !rd_mid);
    end

    // Running disparity follows every received group, valid or not
    always_ff @(posedge clock or negedge mr_main_reset) begin
        if (!mr_main_reset) rd_q <= 1'b0;
        else                rd_q <= rd_d;
    end
`else
    assign disp_ok = 1'b1;
`endif

    // Decode the code group and classify it
    always_comb begin
        six          = SUDI[9:4];
        four         = SUDI[3:0];
        {v6, x5}     = dec6(six);
        {v4, y3}     = dec4(four);
        // K28 groups under 110000 carry the complemented 4b pattern
        {vk4, yk3}   = dec4((six == 6'b110000) ? ~four : four);
        a7           = (four == 4'b0111) || (four == 4'b1000);
        rx_byte      = {y3, x5};
        cls          = CL_BAD;
        if (!disp_ok)
            cls = CL_BAD;
        else if ((six == 6'b001111) || (six == 6'b110000)) begin
            if (vk4 && (yk3 == 3'd5)) cls = CL_K285;
        end
        else if (a7 && ((six == 6'b111010) || (six == 6'b000101))) cls = CL_R;
        else if (a7 && ((six == 6'b110110) || (six == 6'b001001))) cls = CL_S;
        else if (a7 && ((six == 6'b101110) || (six == 6'b010001))) cls = CL_T;
        else if (a7 && ((six == 6'b011110) || (six == 6'b100001))) cls = CL_BAD;
        else if (v6 && v4) cls = CL_D;
    end

    // Receive FSM next state and next GMII outputs
    always_comb begin
        state_d = state_q;
        rxd_d   = rxd_q;
        dv_d    = 1'b0;
        er_d    = 1'b0;
        if (!code_sync_status) begin
            state_d = LINK_FAILED;
            if ((state_q == START_OF_PACKET) || (state_q == RECEIVE)) begin
                dv_d = 1'b1;
                er_d = 1'b1;
            end
        end else begin
            case (state_q)
                LINK_FAILED: state_d = WAIT_FOR_K;
                WAIT_FOR_K: if ((cls == CL_K285) && rx_even) state_d = RX_K;
                RX_K: begin
                    if ((cls == CL_D) && (rx_byte != 8'hB5) && (rx_byte != 8'h42))
                        state_d = IDLE_D;
                    else
                        state_d = WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (cls == CL_K285)
                        state_d = RX_K;
                    else if (cls == CL_S) begin
                        state_d = START_OF_PACKET;
                        dv_d    = 1'b1;
                        rxd_d   = PREAMBLE;
                    end else begin
                        state_d = FALSE_CARRIER;
                        er_d    = 1'b1;
                        rxd_d   = FC_CODE;
                    end
                end
                FALSE_CARRIER: begin
                    if ((cls == CL_K285) && rx_even)
                        state_d = RX_K;
                    else begin
                        er_d  = 1'b1;
                        rxd_d = FC_CODE;
                    end
                end
                // The preamble was emitted on entry; the next group is payload
                START_OF_PACKET, RECEIVE: begin
                    case (cls)
                        CL_D: begin
                            state_d = RECEIVE;
                            dv_d    = 1'b1;
                            rxd_d   = rx_byte;
                        end
                        CL_T: state_d = TRR;
                        CL_K285: begin
                            state_d = RX_K;
                            dv_d    = 1'b1;
                            er_d    = 1'b1;
                        end
                        default: begin
                            state_d = RECEIVE;
                            dv_d    = 1'b1;
                            er_d    = 1'b1;
                        end
                    endcase
                end
                TRR: begin
                    state_d = WAIT_FOR_K;
                    er_d    = (cls != CL_R);
                end
                default: state_d = LINK_FAILED;
            endcase
        end
    end

    // Saturating error count, advancing together with RX_ER
    always_comb begin
        cnt_d = cnt_q;
        if (er_d && (cnt_q != {ERR_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // State and output registers
    always_ff @(posedge clock or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= LINK_FAILED;
            rxd_q   <= 8'h00;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rxd_q   <= rxd_d;
            dv_q    <= dv_d;
            er_q    <= er_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RXD        = rxd_q;
    assign RX_DV      = dv_q;
    assign RX_ER      = er_q;
    assign rx_err_cnt = cnt_q;

endmodule

// File: tb/tb_pcs_receive_decode.sv
// tb/tb_pcs_receive_decode.sv - directed self-checking bench for pcs_receive_decode
module tb_pcs_receive_decode;

    localparam logic [9:0] K285  = 10'b0011111010;
    localparam logic [9:0] D162  = 10'b0110110101;
    localparam logic [9:0] SC    = 10'b1101101000;
    localparam logic [9:0] TC    = 10'b1011101000;
    localparam logic [9:0] RC    = 10'b1110101000;
    localparam logic [9:0] DAA   = 10'b0101011010;
    localparam logic [9:0] D56   = 10'b1010010110;
    localparam logic [9:0] D215  = 10'b1010101010;
    localparam logic [9:0] BAD   = 10'b0000000000;
    localparam logic [9:0] D162P = 10'b1001000101;

    logic       clock = 1'b0;
    logic       mr_main_reset;
    logic [9:0] SUDI;
    logic       rx_even;
    logic       code_sync_status;
    logic [7:0] RXD;
    logic       RX_DV, RX_ER;
    logic [7:0] rx_err_cnt;
    logic [7:0] rxd2;
    logic       dv2, er2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pcs_receive_decode dut (
        .clock(clock), .mr_main_reset(mr_main_reset), .SUDI(SUDI), .rx_even(rx_even),
        .code_sync_status(code_sync_status), .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
        .rx_err_cnt(rx_err_cnt)
    );

    pcs_receive_decode #(.ERR_CNT_W(2)) dut_sat (
        .clock(clock), .mr_main_reset(mr_main_reset), .SUDI(SUDI), .rx_even(rx_even),
        .code_sync_status(code_sync_status), .RXD(rxd2), .RX_DV(dv2), .RX_ER(er2),
        .rx_err_cnt(cnt2)
    );

    task automatic send(input logic [9:0] code, input logic even);
        SUDI    = code;
        rx_even = even;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        send(K285, 1'b1);
        send(D162, 1'b0);
    endtask

    task automatic test_reset();
        mr_main_reset    = 1'b0;
        code_sync_status = 1'b0;
        SUDI             = 10'd0;
        rx_even          = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        mr_main_reset = 1'b1;
        send(K285, 1'b1);
        checks++; if (RXD !== 8'h00) begin errors++; $display("FAIL reset_rxd got %0h exp 00", RXD); end
        checks++; if (RX_DV !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b exp 0", RX_DV); end
        checks++; if (RX_ER !== 1'b0) begin errors++; $display("FAIL reset_er got %0b exp 0", RX_ER); end
        checks++; if (rx_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", rx_err_cnt); end
    endtask

    task automatic test_idle();
        code_sync_status = 1'b1;
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            send(K285, 1'b1);
            checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL idle_k dv/er got %b exp 00", {RX_DV, RX_ER}); end
            send(D162, 1'b0);
            checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL idle_d dv/er got %b exp 00", {RX_DV, RX_ER}); end
        end
    endtask

    task automatic test_packet();
        send(SC, 1'b1);
        checks++; if ({RX_DV, RX_ER, RXD} !== {2'b10, 8'h55}) begin errors++; $display("FAIL pkt_sop got dv=%b er=%b rxd=%h exp 1 0 55", RX_DV, RX_ER, RXD); end
        for (int i = 0; i < 4; i++) begin
            send(DAA, i[0]);
            checks++; if ({RX_DV, RX_ER, RXD} !== {2'b10, 8'hAA}) begin errors++; $display("FAIL pkt_data%0d got dv=%b er=%b rxd=%h exp 1 0 aa", i, RX_DV, RX_ER, RXD); end
        end
        send(TC, 1'b0);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL pkt_t got %b exp 00", {RX_DV, RX_ER}); end
        send(RC, 1'b1);
        checks++; if ({RX_DV, RX_ER, RXD} !== {2'b00, 8'hAA}) begin errors++; $display("FAIL pkt_r got dv=%b er=%b rxd=%h exp 0 0 aa", RX_DV, RX_ER, RXD); end
        checks++; if (rx_err_cnt !== 8'd0) begin errors++; $display("FAIL pkt_cnt got %0d exp 0", rx_err_cnt); end
    endtask

    task automatic test_false_carrier();
        idle();
        send(D56, 1'b1);
        checks++; if ({RX_DV, RX_ER, RXD} !== {2'b01, 8'h0E}) begin errors++; $display("FAIL fc_enter got dv=%b er=%b rxd=%h exp 0 1 0e", RX_DV, RX_ER, RXD); end
        send(K285, 1'b0);
        checks++; if ({RX_DV, RX_ER, RXD} !== {2'b01, 8'h0E}) begin errors++; $display("FAIL fc_odd_k got dv=%b er=%b rxd=%h exp 0 1 0e", RX_DV, RX_ER, RXD); end
        send(K285, 1'b1);
        checks++; if ({RX_DV, RX_ER, RXD} !== {2'b00, 8'h0E}) begin errors++; $display("FAIL fc_exit got dv=%b er=%b rxd=%h exp 0 0 0e", RX_DV, RX_ER, RXD); end
        checks++; if (rx_err_cnt !== 8'd2) begin errors++; $display("FAIL fc_cnt got %0d exp 2", rx_err_cnt); end
        send(D162, 1'b0);
    endtask

    task automatic test_config_reject();
        send(K285, 1'b1);
        send(D215, 1'b0);
        send(SC, 1'b1);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL cfg_d215 got %b exp 00", {RX_DV, RX_ER}); end
        idle();
    endtask

    task automatic test_early_end();
        send(SC, 1'b1);
        send(DAA, 1'b0);
        send(K285, 1'b1);
        checks++; if ({RX_DV, RX_ER} !== 2'b11) begin errors++; $display("FAIL early_k got %b exp 11", {RX_DV, RX_ER}); end
        checks++; if (rx_err_cnt !== 8'd3) begin errors++; $display("FAIL early_cnt got %0d exp 3", rx_err_cnt); end
        send(D162, 1'b0);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL early_after got %b exp 00", {RX_DV, RX_ER}); end
        send(SC, 1'b1);
        checks++; if ({RX_DV, RXD} !== {1'b1, 8'h55}) begin errors++; $display("FAIL early_resop got dv=%b rxd=%h exp 1 55", RX_DV, RXD); end
        send(TC, 1'b0);
        send(RC, 1'b1);
    endtask

    task automatic test_link_loss();
        idle();
        send(SC, 1'b0);
        send(DAA, 1'b1);
        code_sync_status = 1'b0;
        send(DAA, 1'b0);
        checks++; if ({RX_DV, RX_ER} !== 2'b11) begin errors++; $display("FAIL loss_cycle got %b exp 11", {RX_DV, RX_ER}); end
        send(DAA, 1'b1);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL loss_after got %b exp 00", {RX_DV, RX_ER}); end
        send(K285, 1'b1);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL loss_hold got %b exp 00", {RX_DV, RX_ER}); end
        checks++; if (rx_err_cnt !== 8'd4) begin errors++; $display("FAIL loss_cnt got %0d exp 4", rx_err_cnt); end
    endtask

    task automatic test_trr_error();
        code_sync_status = 1'b1;
        idle();
        idle();
        send(SC, 1'b1);
        send(DAA, 1'b0);
        send(TC, 1'b1);
        send(D162, 1'b0);
        checks++; if ({RX_DV, RX_ER} !== 2'b01) begin errors++; $display("FAIL trr_err got %b exp 01", {RX_DV, RX_ER}); end
        send(K285, 1'b1);
        checks++; if ({RX_DV, RX_ER} !== 2'b00) begin errors++; $display("FAIL trr_after got %b exp 00", {RX_DV, RX_ER}); end
        checks++; if (rx_err_cnt !== 8'd5) begin errors++; $display("FAIL trr_cnt got %0d exp 5", rx_err_cnt); end
        send(D162, 1'b0);
    endtask

    task automatic test_reset_and_saturation();
        send(SC, 1'b1);
        send(DAA, 1'b0);
        #2;
        mr_main_reset = 1'b0;
        #1;
        checks++; if ({RX_DV, RX_ER, RXD} !== 10'd0) begin errors++; $display("FAIL async_rst got dv=%b er=%b rxd=%h exp 0 0 00", RX_DV, RX_ER, RXD); end
        checks++; if (rx_err_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", rx_err_cnt); end
        @(posedge clock);
        #1;
        mr_main_reset = 1'b1;
        idle();
        idle();
        send(SC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(BAD, i[0]);
            checks++; if ({RX_DV, RX_ER} !== 2'b11) begin errors++; $display("FAIL sat_err%0d got %b exp 11", i, {RX_DV, RX_ER}); end
        end
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp 3", cnt2); end
        checks++; if (rx_err_cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got %0d exp 5", rx_err_cnt); end
        send(TC, 1'b0);
        send(RC, 1'b1);
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", cnt2); end
    endtask

    task automatic test_disparity();
        code_sync_status = 1'b1;
        send(K285, 1'b1);
        send(K285, 1'b1);
        send(D162P, 1'b0);
        send(SC, 1'b1);
        checks++; if (RX_DV !== 1'b0) begin errors++; $display("FAIL disp_bad_k got %b exp 0", RX_DV); end
        send(K285, 1'b1);
        send(D162P, 1'b0);
        send(SC, 1'b1);
        checks++; if ({RX_DV, RXD} !== {1'b1, 8'h55}) begin errors++; $display("FAIL disp_good got dv=%b rxd=%h exp 1 55", RX_DV, RXD); end
    endtask

    initial begin
        test_reset();
`ifdef RX_DISP_CHECK_EN
        test_disparity();
`else
        test_idle();
        test_packet();
        test_false_carrier();
        test_config_reject();
        test_early_end();
        test_link_loss();
        test_trr_error();
        test_reset_and_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
